// File: rtl/icache_assoc_if.sv
// -----------------------------------------------------------------------------
// icache_assoc_if
// Bundles the fetch-side and refill-side signals of the associative icache.
//   Fetch side : imemREN, imemaddr -> ihit, imemload ; inv (invalidate all)
//   Refill side: iREN, iaddr -> memory ; iwait, iload <- memory
//   Status     : busy (refill in progress), hit_cnt, miss_cnt (saturating)
// Modports:
//   slave  - the cache itself
//   master - whoever drives fetches and models memory
// -----------------------------------------------------------------------------
interface icache_assoc_if #(
  parameter int CNT_W = 32
);
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             inv;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport slave (
    input  imemREN, imemaddr, inv, iwait, iload,
    output ihit, imemload, iREN, iaddr, busy, hit_cnt, miss_cnt
  );

  modport master (
    output imemREN, imemaddr, inv, iwait, iload,
    input  ihit, imemload, iREN, iaddr, busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_assoc.sv
// -----------------------------------------------------------------------------
// icache_assoc
// Parametrised set-associative instruction cache with true-LRU replacement,
// bulk invalidate and saturating hit/miss counters.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - synchronous active-high reset
//   bus  - icache_assoc_if.slave: fetch request/response, memory refill
//          handshake (iREN/iaddr/iwait/iload), busy and performance counters
// Hits are answered combinationally in IDLE. A miss latches the block base
// and a victim way, then FILL streams WORDS words from memory into the victim.
// -----------------------------------------------------------------------------
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  icache_assoc_if.slave bus
);

  localparam int WO = $clog2(WORDS);            // word-offset bits (0 if WORDS=1)
  localparam int IW = $clog2(SETS);             // index bits
  localparam int TW = 30 - WO - IW;             // tag bits
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = (WO > 0) ? WO : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]    victim_q, victim_d;
  logic             pend_inv_q, pend_inv_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  valid_d [WAYS];
  logic [AW-1:0]    age_q [SETS][WAYS];
  logic [AW-1:0]    age_d [SETS][WAYS];

  // Line storage; never reset, qualified by the valid bits.
  logic [TW-1:0]    tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS][WORDS];

  logic [IW-1:0]    req_set, fill_set, lru_set;
  logic [TW-1:0]    req_tag, fill_tag;
  logic [CW-1:0]    req_word;
  logic [WAYS-1:0]  way_hit;
  logic [AW-1:0]    hit_way, victim_sel, lru_way;
  logic             found_inv;
  logic             inv_eff, lookup, lookup_hit, lookup_miss;
  logic             fill_accept, fill_last, lru_en;
  logic [1:0]       unused_byte_off;

  assign req_set         = bus.imemaddr[2+WO +: IW];
  assign req_tag         = bus.imemaddr[31 -: TW];
  assign fill_set        = base_q[2+WO +: IW];
  assign fill_tag        = base_q[31 -: TW];
  assign unused_byte_off = bus.imemaddr[1:0];

  generate
    if (WO > 0) begin : g_word_sel
      assign req_word = bus.imemaddr[2 +: WO];
    end else begin : g_word_zero
      assign req_word = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way_match
      assign way_hit[gi] = valid_q[gi][req_set] && (tag_mem[gi][req_set] == req_tag);
    end
  endgenerate

  // A pending invalidate from a fill behaves like inv for the first IDLE cycle.
  assign inv_eff     = bus.inv | pend_inv_q;
  assign lookup      = (state_q == S_IDLE) && bus.imemREN && !inv_eff;
  assign lookup_hit  = lookup && (|way_hit);
  assign lookup_miss = lookup && !(|way_hit);
  assign fill_accept = (state_q == S_FILL) && !bus.iwait;
  assign fill_last   = fill_accept && (fill_cnt_q == CW'(WORDS - 1));

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = AW'(w);
    end
  end

  // Victim: lowest invalid way wins, otherwise the least recently used one.
  always_comb begin
    victim_sel = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[req_set][w] == AW'(WAYS - 1)) victim_sel = AW'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][req_set]) begin
        victim_sel = AW'(w);
        found_inv  = 1'b1;
      end
    end
  end

  // True LRU: touched way becomes age 0, younger ways age by one.
  assign lru_en  = lookup_hit | fill_last;
  assign lru_set = lookup_hit ? req_set : fill_set;
  assign lru_way = lookup_hit ? hit_way : victim_q;

  always_comb begin
    age_d = age_q;
    if (lru_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == lru_way) begin
          age_d[lru_set][w] = '0;
        end else if (age_q[lru_set][w] < age_q[lru_set][lru_way]) begin
          age_d[lru_set][w] = age_q[lru_set][w] + AW'(1);
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_last) valid_d[victim_q][fill_set] = 1'b1;
    if ((state_q == S_IDLE) && inv_eff) begin
      for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
    end
  end

  // Remaining datapath state.
  always_comb begin
    base_d     = base_q;
    fill_cnt_d = fill_cnt_q;
    victim_d   = victim_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    pend_inv_d = (state_q == S_FILL) ? (pend_inv_q | bus.inv) : 1'b0;
    if (lookup_miss) begin
      base_d     = bus.imemaddr & ~(32'(WORDS * 4) - 32'd1);
      fill_cnt_d = '0;
      victim_d   = victim_sel;
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
    end
    if (fill_accept) fill_cnt_d = fill_last ? '0 : fill_cnt_q + 1'b1;
    if (lookup_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
  end

  // FSM: state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      fill_cnt_q <= '0;
      victim_q   <= '0;
      pend_inv_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      fill_cnt_q <= fill_cnt_d;
      victim_q   <= victim_d;
      pend_inv_q <= pend_inv_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  // Line writes; suppressed under reset so an aborted fill leaves no trace.
  always_ff @(posedge CLK) begin
    if (!RST && fill_accept) data_mem[victim_q][fill_set][fill_cnt_q] <= bus.iload;
    if (!RST && fill_last)   tag_mem[victim_q][fill_set] <= fill_tag;
  end

  // FSM: next state. A fill always runs to completion once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lookup_miss) state_d = S_FILL;
      S_FILL:  if (fill_last)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    bus.ihit     = lookup_hit;
    bus.imemload = lookup_hit ? data_mem[hit_way][req_set][req_word] : 32'd0;
    bus.iREN     = (state_q == S_FILL);
    bus.busy     = (state_q == S_FILL);
    bus.iaddr    = (state_q == S_FILL) ?
                   base_q + {{(30 - CW){1'b0}}, fill_cnt_q, 2'b00} : 32'd0;
    bus.hit_cnt  = hit_cnt_q;
    bus.miss_cnt = miss_cnt_q;
  end

endmodule

// File: tb/tb_icache_assoc.sv
// -----------------------------------------------------------------------------
// tb_icache_assoc
// Directed bench for icache_assoc (SETS=8, WAYS=2, WORDS=2, CNT_W=4).
// Expected fetch data and expected memory word addresses are queued when a
// fetch is issued and popped when the cache delivers them.
// -----------------------------------------------------------------------------
module tb_icache_assoc;
  localparam int CNT_W = 4;
  localparam int WORDS = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_assoc_if #(.CNT_W(CNT_W)) bus ();

  icache_assoc #(.SETS(8), .WAYS(2), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wait_n   = 0;
  int wcnt     = 0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [3:0]  hit_exp, miss_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Memory model: wait_n stall cycles before each word is accepted.
  assign bus.iwait = bus.iREN && (wcnt < wait_n);
  assign bus.iload = mem_word(bus.iaddr);
  always @(posedge CLK) begin
    if (RST || !bus.iREN || !bus.iwait) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    #1;
    check({tag, "_hit_cnt"},  32'(bus.hit_cnt),  32'(hit_exp));
    check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'(miss_exp));
  endtask

  task automatic push_block(input logic [31:0] addr);
    for (int k = 0; k < WORDS; k++)
      exp_addr_q.push_back((addr & ~32'(WORDS * 4 - 1)) + 32'(4 * k));
  endtask

  // Refill monitor: iaddr must equal the queued word address while requested.
  always @(negedge CLK) begin
    #2;
    if (bus.iREN) begin
      if (exp_addr_q.size() == 0) begin
        check("iaddr_unexpected", bus.iaddr, 32'hFFFF_FFFF);
      end else begin
        check("iaddr", bus.iaddr, exp_addr_q[0]);
        if (!bus.iwait) begin
          $display("mem   read  iaddr=%h iload=%h", bus.iaddr, bus.iload);
          void'(exp_addr_q.pop_front());
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input bit drop);
    int cycles;
    int busy_cycles;
    bit seen;
    logic [31:0] exp_d;
    cycles = 0;
    busy_cycles = 0;
    exp_data_q.push_back(mem_word(addr));
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    if (exp_hit) begin
      check("hit_now", 32'(bus.ihit), 32'd1);
      seen = bus.ihit;
    end else begin
      check("miss_now", 32'(bus.ihit), 32'd0);
      miss_exp = sat_inc(miss_exp);
      push_block(addr);
      seen = 1'b0;
      while (!seen && cycles < 100) begin
        @(negedge CLK);
        cycles++;
        if (drop) begin
          if (bus.busy) begin
            bus.imemREN  = 1'b0;
            bus.imemaddr = 32'hDEAD_BEE0;
          end else begin
            bus.imemREN  = 1'b1;
            bus.imemaddr = addr;
          end
        end
        #1;
        if (bus.busy) busy_cycles++;
        seen = bus.ihit;
      end
      check("fill_done", 32'(seen), 32'd1);
      check("miss_latency", 32'(cycles), 32'(1 + WORDS * (wait_n + 1)));
      check("busy_cycles", 32'(busy_cycles), 32'(WORDS * (wait_n + 1)));
    end
    if (seen) hit_exp = sat_inc(hit_exp);
    exp_d = exp_data_q.pop_front();
    check("imemload", bus.imemload, exp_d);
    $display("fetch addr=%h %s latency=%0d imemload=%h", addr,
             exp_hit ? "hit " : "miss", cycles, bus.imemload);
    @(negedge CLK);
    bus.imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'd0;
    bus.inv      = 1'b0;
    hit_exp      = 4'd0;
    miss_exp     = 4'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_ihit",     32'(bus.ihit), 32'd0);
    check("rst_iREN",     32'(bus.iREN), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_iaddr",    bus.iaddr,     32'd0);
    check("rst_imemload", bus.imemload,  32'd0);
    chk_cnt("rst");

    // Cold miss then zero-latency hit on the other word of the block.
    fetch(32'h40, 1'b0, 1'b0);
    fetch(32'h44, 1'b1, 1'b0);
    chk_cnt("cold");

    // Same-index conflicts: 0xC0 must evict the LRU 0x80 line.
    fetch(32'h80, 1'b0, 1'b0);
    fetch(32'h40, 1'b1, 1'b0);
    fetch(32'hC0, 1'b0, 1'b0);
    fetch(32'h40, 1'b1, 1'b0);
    fetch(32'h80, 1'b0, 1'b0);
    chk_cnt("lru");

    // Slow memory, request dropped and address changed mid-fill.
    wait_n = 3;
    fetch(32'h108, 1'b0, 1'b1);
    wait_n = 0;
    fetch(32'h10C, 1'b1, 1'b0);
    chk_cnt("wait");

    // Invalidate in IDLE while 0x40 is resident.
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.inv      = 1'b1;
    #1;
    check("inv_idle_ihit",     32'(bus.ihit), 32'd0);
    check("inv_idle_imemload", bus.imemload,  32'd0);
    @(negedge CLK);
    bus.inv     = 1'b0;
    bus.imemREN = 1'b0;
    fetch(32'h40, 1'b0, 1'b0);
    chk_cnt("inv_idle");

    // Invalidate during a fill: line completes but is dropped afterwards.
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h200;
    push_block(32'h200);
    miss_exp = sat_inc(miss_exp);
    #1;
    check("invfill_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    bus.inv     = 1'b1;
    #1;
    check("invfill_busy0", 32'(bus.busy), 32'd1);
    @(negedge CLK);
    bus.inv = 1'b0;
    #1;
    check("invfill_busy1", 32'(bus.busy), 32'd1);
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h200;
    #1;
    check("invfill_idle_busy", 32'(bus.busy), 32'd0);
    check("invfill_pend_ihit", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    fetch(32'h200, 1'b0, 1'b0);
    chk_cnt("inv_fill");

    // Reset on the second word of a refill.
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h300;
    push_block(32'h300);
    #1;
    check("rstfill_miss", 32'(bus.ihit), 32'd0);
    @(negedge CLK);
    #1;
    check("rstfill_iREN_w0", 32'(bus.iREN), 32'd1);
    @(negedge CLK);
    RST         = 1'b1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    RST      = 1'b0;
    hit_exp  = 4'd0;
    miss_exp = 4'd0;
    #1;
    check("rstfill_iREN", 32'(bus.iREN), 32'd0);
    check("rstfill_ihit", 32'(bus.ihit), 32'd0);
    check("rstfill_busy", 32'(bus.busy), 32'd0);
    chk_cnt("rstfill");
    fetch(32'h300, 1'b0, 1'b0);
    fetch(32'h40, 1'b0, 1'b0);
    chk_cnt("after_rst");

    // Hit counter saturation at 4'hF.
    for (int i = 0; i < 20; i++) fetch(32'h40, 1'b1, 1'b0);
    chk_cnt("sat");
    check("hit_sat", 32'(bus.hit_cnt), 32'h0000_000F);

    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("data_q_empty", 32'(exp_data_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
